// File: rtl/vga_gr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : vga_gr_pkg                                                 |
// | Shared types and constants for the VGA graphics write datapath.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_gr_pkg;

    localparam int NPLANES = 4;
    localparam int PLANE_W = 8;

    typedef enum logic [1:0] {
        WM0 = 2'd0,
        WM1 = 2'd1,
        WM2 = 2'd2,
        WM3 = 2'd3
    } gr_wmode_t;

    typedef enum logic [1:0] {
        FN_PASS = 2'd0,
        FN_AND  = 2'd1,
        FN_OR   = 2'd2,
        FN_XOR  = 2'd3
    } gr_fn_t;

    // Graphics register fields captured with each accepted write
    typedef struct packed {
        logic [NPLANES-1:0] sr;
        logic [NPLANES-1:0] esr;
        logic [2:0]         rot;
        gr_fn_t             fn;
        gr_wmode_t          wm;
        logic [PLANE_W-1:0] mask;
    } gr_snap_t;

    function automatic logic [PLANE_W-1:0] gr_rotr(input logic [PLANE_W-1:0] d,
                                                   input logic [2:0]         n);
        logic [2*PLANE_W-1:0] w_t;
        w_t = {d, d} >> n;
        return w_t[PLANE_W-1:0];
    endfunction

endpackage : vga_gr_pkg
`default_nettype wire

// File: rtl/gr_plane_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gr_plane_alu                                               |
// | One plane: source select, logical op with latch, bit-mask merge.     |
// | Macro GR_WMODE3_EN enables write mode 3; otherwise mode 3 acts as 0. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gr_plane_alu
    import vga_gr_pkg::*;
(
    input  gr_wmode_t          i_wmode,
    input  gr_fn_t             i_fn,
    input  logic [PLANE_W-1:0] i_rot,
    input  logic               i_wr_bit,
    input  logic               i_sr_bit,
    input  logic               i_esr_bit,
    input  logic [PLANE_W-1:0] i_mask,
    input  logic [PLANE_W-1:0] i_lat,
    output logic [PLANE_W-1:0] o_data
);

    logic [PLANE_W-1:0] w_src;
    logic [PLANE_W-1:0] w_msk;
    logic [PLANE_W-1:0] w_alu;

    always_comb begin
        w_src = i_rot;
        w_msk = i_mask;
        case (i_wmode)
            WM1: begin
                // Latch copy: a zero mask selects the latch byte unchanged
                w_src = i_lat;
                w_msk = '0;
            end
            WM2: begin
                w_src = {PLANE_W{i_wr_bit}};
            end
`ifdef GR_WMODE3_EN
            WM3: begin
                w_src = {PLANE_W{i_sr_bit}};
                w_msk = i_rot & i_mask;
            end
`endif
            default: begin
                w_src = i_esr_bit ? {PLANE_W{i_sr_bit}} : i_rot;
            end
        endcase
    end

    always_comb begin
        w_alu = w_src;
        case (i_fn)
            FN_PASS: w_alu = w_src;
            FN_AND:  w_alu = w_src & i_lat;
            FN_OR:   w_alu = w_src | i_lat;
            FN_XOR:  w_alu = w_src ^ i_lat;
        endcase
    end

    assign o_data = (w_alu & w_msk) | (i_lat & ~w_msk);

endmodule : gr_plane_alu
`default_nettype wire

// File: rtl/gr_write_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gr_write_pipe                                              |
// | Two-stage host-to-display-memory write pipe with plane latches.      |
// | Macro GR_WMODE3_EN enables write mode 3; otherwise mode 3 acts as 0. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gr_write_pipe
    import vga_gr_pkg::*;
(
    input  logic        h_hclk,
    input  logic        h_reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_data,
    input  logic [16:0] wr_addr,
    input  logic [3:0]  gr0_sr,
    input  logic [3:0]  gr1_esr,
    input  logic [2:0]  gr3_rot,
    input  logic [1:0]  gr3_fn,
    input  logic [1:0]  gr5_wm,
    input  logic [7:0]  gr8_mask,
    input  logic [3:0]  sr2_map,
    input  logic        lat_ld,
    input  logic [31:0] mem_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_data,
    output logic [16:0] mem_addr,
    output logic [3:0]  mem_pen,
    output logic [31:0] lat_q
);

    logic               r_s1_vld;
    logic [7:0]         r_s1_data;
    logic [16:0]        r_s1_addr;
    logic [3:0]         r_s1_map;
    gr_snap_t           r_s1_snap;

    logic               r_s2_vld;
    logic [31:0]        r_s2_data;
    logic [16:0]        r_s2_addr;
    logic [3:0]         r_s2_pen;

    logic [31:0]        r_lat_q;

    logic               w_s1_adv;
    logic               w_accept;
    logic [PLANE_W-1:0] w_rot;
    logic [31:0]        w_word;
    gr_snap_t           w_snap_in;

    assign w_s1_adv = ~r_s2_vld | mem_ready;
    assign wr_ready = ~r_s1_vld | w_s1_adv;
    assign w_accept = wr_valid & wr_ready;

    assign w_snap_in = '{sr:   gr0_sr,
                         esr:  gr1_esr,
                         rot:  gr3_rot,
                         fn:   gr_fn_t'(gr3_fn),
                         wm:   gr_wmode_t'(gr5_wm),
                         mask: gr8_mask};

    always_ff @(posedge h_hclk) begin
        if (h_reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
            r_s1_addr <= '0;
            r_s1_map  <= '0;
            r_s1_snap <= '0;
        end else begin
            if (w_accept) begin
                r_s1_vld  <= 1'b1;
                r_s1_data <= wr_data;
                r_s1_addr <= wr_addr;
                r_s1_map  <= sr2_map;
                r_s1_snap <= w_snap_in;
            end else if (w_s1_adv) begin
                r_s1_vld  <= 1'b0;
            end
        end
    end

    assign w_rot = gr_rotr(r_s1_data, r_s1_snap.rot);

    generate
        for (genvar p = 0; p < NPLANES; p++) begin : g_plane
            gr_plane_alu u_alu (
                .i_wmode   (r_s1_snap.wm),
                .i_fn      (r_s1_snap.fn),
                .i_rot     (w_rot),
                .i_wr_bit  (r_s1_data[p]),
                .i_sr_bit  (r_s1_snap.sr[p]),
                .i_esr_bit (r_s1_snap.esr[p]),
                .i_mask    (r_s1_snap.mask),
                .i_lat     (r_lat_q[p*PLANE_W +: PLANE_W]),
                .o_data    (w_word[p*PLANE_W +: PLANE_W])
            );
        end
    endgenerate

    // Output stage samples the latch value present while S1 advances
    always_ff @(posedge h_hclk) begin
        if (h_reset) begin
            r_s2_vld  <= 1'b0;
            r_s2_data <= '0;
            r_s2_addr <= '0;
            r_s2_pen  <= '0;
        end else if (w_s1_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_data <= w_word;
                r_s2_addr <= r_s1_addr;
                r_s2_pen  <= r_s1_map;
            end
        end
    end

    always_ff @(posedge h_hclk) begin
        if (h_reset) begin
            r_lat_q <= '0;
        end else if (lat_ld) begin
            r_lat_q <= mem_rdata;
        end
    end

    assign mem_valid = r_s2_vld;
    assign mem_data  = r_s2_data;
    assign mem_addr  = r_s2_addr;
    assign mem_pen   = r_s2_pen;
    assign lat_q     = r_lat_q;

endmodule : gr_write_pipe
`default_nettype wire

// File: tb/tb_gr_write_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_gr_write_pipe                                           |
// | Randomized and directed bench for gr_write_pipe with a reference model.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gr_write_pipe;

    logic        h_hclk = 1'b0;
    logic        h_reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic [16:0] wr_addr;
    logic [3:0]  gr0_sr;
    logic [3:0]  gr1_esr;
    logic [2:0]  gr3_rot;
    logic [1:0]  gr3_fn;
    logic [1:0]  gr5_wm;
    logic [7:0]  gr8_mask;
    logic [3:0]  sr2_map;
    logic        lat_ld;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic [16:0] mem_addr;
    logic [3:0]  mem_pen;
    logic [31:0] lat_q;

    gr_write_pipe dut (
        .h_hclk    (h_hclk),
        .h_reset   (h_reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_addr   (wr_addr),
        .gr0_sr    (gr0_sr),
        .gr1_esr   (gr1_esr),
        .gr3_rot   (gr3_rot),
        .gr3_fn    (gr3_fn),
        .gr5_wm    (gr5_wm),
        .gr8_mask  (gr8_mask),
        .sr2_map   (sr2_map),
        .lat_ld    (lat_ld),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_data  (mem_data),
        .mem_addr  (mem_addr),
        .mem_pen   (mem_pen),
        .lat_q     (lat_q)
    );

    always #5 h_hclk = ~h_hclk;

    typedef struct {
        int d, a, map, sr, esr, rot, fn, wm, mask;
    } txn_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_out = 0;

    // Transaction-level view: at most one write waiting, one presented
    bit          m_s1_vld = 0;
    txn_t        m_s1;
    bit          m_s2_vld = 0;
    logic [31:0] m_s2_data;
    logic [16:0] m_s2_addr;
    logic [3:0]  m_s2_pen;
    logic [31:0] m_lat = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input txn_t t, input logic [31:0] lat);
        int wm, rotv, latb, src, msk, alu, res;
        logic [31:0] word;
        word = '0;
        wm = t.wm;
`ifndef GR_WMODE3_EN
        if (wm == 3) wm = 0;
`endif
        rotv = ((t.d >> t.rot) | (t.d << (8 - t.rot))) & 255;
        for (int p = 0; p < 4; p++) begin
            latb = int'((lat >> (8 * p)) & 32'hFF);
            src  = rotv;
            msk  = t.mask;
            case (wm)
                0: src = ((t.esr >> p) & 1) != 0 ? (((t.sr >> p) & 1) != 0 ? 255 : 0) : rotv;
                1: begin src = latb; msk = 0; end
                2: src = ((t.d >> p) & 1) != 0 ? 255 : 0;
                default: begin
                    src = ((t.sr >> p) & 1) != 0 ? 255 : 0;
                    msk = rotv & t.mask;
                end
            endcase
            case (t.fn)
                1: alu = src & latb;
                2: alu = src | latb;
                3: alu = src ^ latb;
                default: alu = src;
            endcase
            res  = ((alu & msk) | (latb & ~msk)) & 255;
            word = word | (32'(res) << (8 * p));
        end
        return word;
    endfunction

    // Check one cycle of DUT outputs, then step the model across the next edge
    task automatic tick();
        bit   adv, rdy, acc;
        txn_t t;
        #1;
        adv = !m_s2_vld || mem_ready;
        rdy = !m_s1_vld || adv;
        chk("wr_ready", 32'(wr_ready), 32'(rdy));
        chk("mem_valid", 32'(mem_valid), 32'(m_s2_vld));
        chk("lat_q", lat_q, m_lat);
        if (m_s2_vld) begin
            chk("mem_data", mem_data, m_s2_data);
            chk("mem_addr", 32'(mem_addr), 32'(m_s2_addr));
            chk("mem_pen", 32'(mem_pen), 32'(m_s2_pen));
        end
        acc = wr_valid && rdy;
        if (h_reset) begin
            m_s1_vld = 0;
            m_s2_vld = 0;
            m_lat    = '0;
            n_acc    = 0;
            n_out    = 0;
        end else begin
            if (m_s2_vld && mem_ready) n_out++;
            if (adv) begin
                if (m_s1_vld) begin
                    m_s2_data = ref_word(m_s1, m_lat);
                    m_s2_addr = 17'(m_s1.a);
                    m_s2_pen  = 4'(m_s1.map);
                end
                m_s2_vld = m_s1_vld;
                m_s1_vld = 0;
            end
            if (acc) begin
                t.d = wr_data; t.a = wr_addr; t.map = sr2_map; t.sr = gr0_sr;
                t.esr = gr1_esr; t.rot = gr3_rot; t.fn = gr3_fn; t.wm = gr5_wm;
                t.mask = gr8_mask;
                m_s1     = t;
                m_s1_vld = 1;
                n_acc++;
            end
            if (lat_ld) m_lat = mem_rdata;
        end
        @(posedge h_hclk);
        @(negedge h_hclk);
    endtask

    task automatic set_fields(input int wm, input int fn, input int rot, input int esr,
                              input int sr, input int mask, input int d, input int map);
        gr5_wm   = 2'(wm);
        gr3_fn   = 2'(fn);
        gr3_rot  = 3'(rot);
        gr1_esr  = 4'(esr);
        gr0_sr   = 4'(sr);
        gr8_mask = 8'(mask);
        wr_data  = 8'(d);
        sr2_map  = 4'(map);
        wr_addr  = 17'($urandom);
    endtask

    task automatic load_lat(input logic [31:0] v);
        lat_ld    = 1'b1;
        mem_rdata = v;
        tick();
        lat_ld    = 1'b0;
        mem_rdata = $urandom;
    endtask

    task automatic dir_write(input string tag, input logic [31:0] exp);
        logic [3:0] map;
        map       = sr2_map;
        wr_valid  = 1'b1;
        mem_ready = 1'b1;
        tick();
        wr_valid  = 1'b0;
        tick();
        #1;
        chk(tag, mem_data, exp);
        chk({tag, "_pen"}, 32'(mem_pen), 32'(map));
        tick();
    endtask

    initial begin
        h_reset = 1'b1; wr_valid = 1'b0; lat_ld = 1'b0; mem_ready = 1'b0;
        mem_rdata = '0;
        set_fields(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge h_hclk);
        @(negedge h_hclk);
        h_reset = 1'b0;

        #1;
        chk("rst_mem_data", mem_data, 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_pen", 32'(mem_pen), 32'h0);
        #1;
        tick();

        // WM0 rotate and AND with latch
        load_lat(32'hF0F0F0F0);
        set_fields(0, 1, 1, 4'b0000, 0, 8'hFF, 8'h0F, 4'b1011);
        dir_write("wm0_rot_and", 32'h80808080);

        // WM0 set/reset with partial mask
        load_lat(32'hAAAAAAAA);
        set_fields(0, 0, 0, 4'b0101, 4'b0001, 8'h0F, 8'hFF, 4'b1111);
        dir_write("wm0_setreset", 32'hAFA0AFAF);

        // WM1 latch copy ignores data and mask
        load_lat(32'h12345678);
        set_fields(1, 3, 5, 4'hF, 4'h3, 8'h5A, 8'hC3, 4'b0110);
        dir_write("wm1_copy", 32'h12345678);

        // WM2 bit expansion with XOR
        load_lat(32'h0);
        set_fields(2, 3, 0, 0, 0, 8'hFF, 8'h05, 4'b0101);
        dir_write("wm2_xor", 32'h00FF00FF);

        // Same result whether mode 3 is built in or folds to mode 0
        set_fields(3, 0, 0, 0, 4'hF, 8'hF0, 8'h3C, 4'b1111);
        dir_write("wm3_mask", 32'h30303030);

        // Three back-to-back writes against a stalled memory, fn changed in flight
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_fields(0, i, i, 0, 0, 8'hFF, 8'h11 * (i + 1), 4'hF);
            wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        gr3_fn   = 2'd3;
        lat_ld   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        lat_ld   = 1'b0;
        mem_ready = 1'b1;
        repeat (4) tick();
        chk("bp_count", 32'(n_out), 32'(n_acc));

        // Reset while stalled with two writes held
        load_lat(32'h5A5A5A5A);
        mem_ready = 1'b0;
        wr_valid  = 1'b1;
        repeat (3) tick();
        h_reset   = 1'b1;
        tick();
        h_reset   = 1'b0;
        wr_valid  = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(mem_valid), 32'h0);
        chk("rst_mid_lat", lat_q, 32'h0);
        chk("rst_mid_ready", 32'(wr_ready), 32'h1);
        tick();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            wr_valid  = ($urandom_range(0, 9) < 7);
            mem_ready = ($urandom_range(0, 9) < 6);
            lat_ld    = ($urandom_range(0, 4) == 0);
            mem_rdata = $urandom;
            h_reset   = ($urandom_range(0, 149) == 0);
            set_fields($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7),
                       $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255),
                       $urandom_range(0, 255), $urandom_range(0, 15));
            tick();
        end
        h_reset   = 1'b0;
        wr_valid  = 1'b0;
        lat_ld    = 1'b0;
        mem_ready = 1'b1;
        repeat (4) tick();
        chk("final_count", 32'(n_out), 32'(n_acc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_gr_write_pipe
`default_nettype wire
